// File: rtl/nbit_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg_pkg
// Description : Shared constants for the nbit_reg register slice.
//               NBIT_REG_DEFAULT_WIDTH - default datapath word size in bits.
// Revision    : 1.0 - initial release
// ============================================================================
package nbit_reg_pkg;

    localparam int NBIT_REG_DEFAULT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/nbit_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg_if
// Description : Data/enable bundle for nbit_reg.
//               in      - data to capture (N bits)
//               we      - local write enable, active-high
//               gwe     - global write enable, active-high
//               out     - registered value (N bits)
//               out_byp - write-through view (only with NBIT_REG_BYPASS_EN)
//               master  - producer/consumer side; slave - register side.
// Revision    : 1.0 - initial release
// ============================================================================
interface nbit_reg_if
    import nbit_reg_pkg::*;
#(
    parameter int N = NBIT_REG_DEFAULT_WIDTH
);

    logic [N-1:0] in;
    logic         we;
    logic         gwe;
    logic [N-1:0] out;
`ifdef NBIT_REG_BYPASS_EN
    logic [N-1:0] out_byp;
`endif

    modport master (
        output in,
        output we,
        output gwe,
        input  out
`ifdef NBIT_REG_BYPASS_EN
        ,
        input  out_byp
`endif
    );

    modport slave (
        input  in,
        input  we,
        input  gwe,
        output out
`ifdef NBIT_REG_BYPASS_EN
        ,
        output out_byp
`endif
    );

endinterface
`default_nettype wire

// File: rtl/nbit_reg_bit.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg_bit
// Description : One-bit enable flop with asynchronous active-high reset to a
//               per-instance constant.
//               clk - clock, rising edge
//               rst - asynchronous reset, active-high; q forced to RST_VAL
//               en  - capture enable
//               d   - data in
//               q   - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_reg_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic d,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/nbit_reg.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg
// Description : N-bit register with local and global write enables and an
//               asynchronous reset to the constant R. Used for the PC,
//               register file entries, pipeline latches and the BRAM read
//               port time-multiplexing latch.
//               Parameters: N - width (1..64), R - reset value (N bits).
//               Ports: clk, rst (async, active-high), bus (nbit_reg_if.slave:
//               in, we, gwe -> out [, out_byp]).
//               Optional macro NBIT_REG_BYPASS_EN adds out_byp, a
//               combinational write-through view of the value being written.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_reg
    import nbit_reg_pkg::*;
#(
    parameter int           N = NBIT_REG_DEFAULT_WIDTH,
    parameter logic [N-1:0] R = '0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    nbit_reg_if.slave  bus
);

    // A write requires both enables; gwe lets a stall freeze every register
    // regardless of its local enable.
    logic         w_en;
    logic [N-1:0] w_q;

    assign w_en = bus.we & bus.gwe;

    // Each bit takes its own reset constant from R, so no reset mux is shared
    // across the word.
    for (genvar i = 0; i < N; i++) begin : g_bit
        nbit_reg_bit #(
            .RST_VAL (R[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .en  (w_en),
            .d   (bus.in[i]),
            .q   (w_q[i])
        );
    end

    assign bus.out = w_q;

`ifdef NBIT_REG_BYPASS_EN
    // Reset dominates, so the bypass view agrees with out while rst is high.
    assign bus.out_byp = rst  ? R      :
                         w_en ? bus.in : w_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbit_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_reg
// Description : Self-checking bench for nbit_reg. Four instances cover the
//               default parameters, a non-zero reset value and the 1-bit and
//               64-bit width corners. A behavioural model per instance holds
//               the expected register value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_reg;

    localparam logic [15:0] RA = 16'hBEEF;
    localparam logic [15:0] RB = 16'h0000;
    localparam logic [0:0]  R1 = 1'b1;
    localparam logic [63:0] R64 = 64'h8000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        gwe;
    logic [15:0] in16;
    logic [0:0]  in1;
    logic [63:0] in64;

    // Reference model state
    logic [15:0] m16a;
    logic [15:0] m16b;
    logic [0:0]  m1;
    logic [63:0] m64;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    nbit_reg_if #(.N(16)) if_a ();
    nbit_reg_if           if_b ();
    nbit_reg_if #(.N(1))  if_c ();
    nbit_reg_if #(.N(64)) if_d ();

    assign if_a.in = in16; assign if_a.we = we; assign if_a.gwe = gwe;
    assign if_b.in = in16; assign if_b.we = we; assign if_b.gwe = gwe;
    assign if_c.in = in1;  assign if_c.we = we; assign if_c.gwe = gwe;
    assign if_d.in = in64; assign if_d.we = we; assign if_d.gwe = gwe;

    nbit_reg #(.N(16), .R(RA))  dut_a (.clk(clk), .rst(rst), .bus(if_a));
    nbit_reg                    dut_b (.clk(clk), .rst(rst), .bus(if_b));
    nbit_reg #(.N(1),  .R(R1))  dut_c (.clk(clk), .rst(rst), .bus(if_c));
    nbit_reg #(.N(64), .R(R64)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m16a = RA; m16b = RB; m1 = R1; m64 = R64;
    endtask

    // Register rule: capture only with rst low and both enables high.
    task automatic model_edge();
        if (!rst && we && gwe) begin
            m16a = in16; m16b = in16; m1 = in1; m64 = in64;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/a"}, {48'd0, if_a.out}, {48'd0, m16a});
        check({tag, "/b"}, {48'd0, if_b.out}, {48'd0, m16b});
        check({tag, "/c"}, {63'd0, if_c.out}, {63'd0, m1});
        check({tag, "/d"}, if_d.out, m64);
    endtask

`ifdef NBIT_REG_BYPASS_EN
    function automatic logic [63:0] byp_exp(input logic [63:0] rv, input logic [63:0] iv,
                                            input logic [63:0] mv);
        return rst ? rv : ((we && gwe) ? iv : mv);
    endfunction

    task automatic check_byp(input string tag);
        check({tag, "/byp_a"}, {48'd0, if_a.out_byp}, byp_exp({48'd0, RA}, {48'd0, in16}, {48'd0, m16a}));
        check({tag, "/byp_b"}, {48'd0, if_b.out_byp}, byp_exp({48'd0, RB}, {48'd0, in16}, {48'd0, m16b}));
        check({tag, "/byp_c"}, {63'd0, if_c.out_byp}, byp_exp({63'd0, R1}, {63'd0, in1}, {63'd0, m1}));
        check({tag, "/byp_d"}, if_d.out_byp, byp_exp(R64, in64, m64));
    endtask
`endif

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; we = 1'b0; gwe = 1'b1;
        in16 = 16'h0; in1 = 1'b0; in64 = 64'h0;
        m16a = 'x; m16b = 'x; m1 = 'x; m64 = 'x;

        // 1. Asynchronous reset while clk is idle, then held across edges.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset_async");
        we = 1'b1; gwe = 1'b1; in16 = 16'h1234; in1 = 1'b0; in64 = 64'h1234;
        for (int i = 0; i < 3; i++) step("reset_hold");

        // 2. Write latency and hold with we=0.
        @(negedge clk);
        rst = 1'b0;
        in16 = 16'h00A5; in1 = 1'b0; in64 = 64'h0000_00A5_0000_00A5;
        #1;
        check_all("write_not_before");
        step("write_latency");
        @(negedge clk);
        we = 1'b0; in16 = 16'h5A00; in1 = 1'b1; in64 = 64'h5A00;
        step("hold_we0");

        // 3. Global freeze.
        @(negedge clk);
        we = 1'b1; gwe = 1'b0; in16 = 16'hFFFF; in1 = 1'b1; in64 = '1;
        for (int i = 0; i < 4; i++) step("gwe_freeze");
        @(negedge clk);
        gwe = 1'b1;
        step("gwe_release");

        // 4. Reset coincident with a write edge.
        @(negedge clk);
        in16 = 16'h7777; in1 = 1'b0; in64 = 64'h7777_7777_7777_7777;
        @(posedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_beats_write");
        @(negedge clk);
        rst = 1'b0;
        step("write_after_rst");

        // 5. Full-width alternating patterns.
        @(negedge clk);
        in16 = 16'h5555; in1 = 1'b1; in64 = 64'h5555_5555_5555_5555;
        step("pattern_55");
        @(negedge clk);
        in16 = 16'hAAAA; in1 = 1'b0; in64 = 64'hAAAA_AAAA_AAAA_AAAA;
        step("pattern_aa");

        // X on in: ignored while held, propagated on a write.
        @(negedge clk);
        we = 1'b0; in16 = 'x; in1 = 'x; in64 = 'x;
        step("x_held");
        @(negedge clk);
        we = 1'b1;
        step("x_written");

`ifdef NBIT_REG_BYPASS_EN
        // 6. Write-through view.
        @(negedge clk);
        in16 = 16'h0C0D; in1 = 1'b1; in64 = 64'h0C0D_0C0D_0C0D_0C0D;
        #1;
        check_byp("byp_same_cycle");
        check_all("byp_out_old");
        step("byp_after_edge");
        check_byp("byp_after_edge");
`endif

        // Randomised enables, data and occasional mid-cycle resets.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 15) == 0);
            we   = 1'($urandom_range(0, 1));
            gwe  = ($urandom_range(0, 3) != 0);
            in16 = 16'($urandom);
            in1  = 1'($urandom);
            in64 = {$urandom, $urandom};
            if (rst) model_reset();
            #1;
            check_all("rand_mid");
`ifdef NBIT_REG_BYPASS_EN
            check_byp("rand_byp");
`endif
            step("rand_edge");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
